// File: rtl/ft_pkg.sv
// ----------------------------------------------------------------------------
// ft_pkg
// Shared definitions for the lockstep monitor: the 3-bit state encoding seen
// on state_o, the mismatch counter width, and a saturating increment helper.
// ----------------------------------------------------------------------------
package ft_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RUN     = 3'd1;
    localparam state_t ST_DONE    = 3'd2;
    localparam state_t ST_TIMEOUT = 3'd3;
    localparam state_t ST_FAULT   = 3'd4;

    localparam int unsigned MIS_CNT_W = 8;

    // Counter sticks at all-ones instead of wrapping back to zero
    function automatic logic [MIS_CNT_W-1:0] satInc(input logic [MIS_CNT_W-1:0] v);
        return (v == {MIS_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ft_majority_voter.sv
// ----------------------------------------------------------------------------
// ft_majority_voter
// Purely combinational plurality voter over NCORES packed W-bit values.
// The voted value is the one shared by the most cores; on a tie the value
// held by the lowest-index core among the tied groups wins.
//
// Ports
//   values_i  in  NCORES*W  core k value at bits [W*k+W-1 : W*k]
//   voted_o   out W         winning value
//   differ_o  out NCORES    bit k set when core k disagrees with voted_o
// ----------------------------------------------------------------------------
module ft_majority_voter #(
    parameter int NCORES = 2,
    parameter int W      = 64
) (
    input  logic [NCORES*W-1:0] values_i,
    output logic [W-1:0]        voted_o,
    output logic [NCORES-1:0]   differ_o
);

    logic [3:0] matchCnt;
    logic [3:0] bestCnt;

    // Count how many cores agree with each core in turn. Only a strictly
    // larger group replaces the current winner, so ties keep the lower index.
    always_comb begin
        matchCnt = '0;
        bestCnt  = '0;
        voted_o  = values_i[W-1:0];
        for (int i = 0; i < NCORES; i++) begin
            matchCnt = '0;
            for (int j = 0; j < NCORES; j++) begin
                if (values_i[i*W +: W] == values_i[j*W +: W]) begin
                    matchCnt = matchCnt + 4'd1;
                end
            end
            if (matchCnt > bestCnt) begin
                bestCnt = matchCnt;
                voted_o = values_i[i*W +: W];
            end
        end
    end

    // Flag every core that disagrees with the winner; with two cores this
    // can only ever be core 1, because core 0 wins any 1:1 split.
    always_comb begin
        differ_o = '0;
        for (int k = 0; k < NCORES; k++) begin
            differ_o[k] = (values_i[k*W +: W] != voted_o);
        end
    end

endmodule

// File: rtl/ft_lockstep_monitor.sv
// ----------------------------------------------------------------------------
// ft_lockstep_monitor
// Watches NCORES cores running the same program in lockstep. Whenever all
// cores commit together their {address, ALU result} tuples are voted; any
// disagreeing core is recorded in a sticky mask and counted. The run ends in
// DONE (memory completion flag), TIMEOUT (cycle limit) or FAULT (too many
// mismatch events), with priority FAULT > DONE > TIMEOUT.
//
// Ports
//   clk_i           in  1          clock, rising edge
//   rst_i           in  1          synchronous active-high reset
//   start_i         in  1          start / restart request (ignored in RUN)
//   core_valid_i    in  NCORES     per-core commit valid
//   instr_addr_i    in  NCORES*32  per-core committed address
//   alu_result_i    in  NCORES*DW  per-core ALU result
//   mem_flag_i      in  1          program completion flag
//   mem_result_i    in  DW         program result word
//   state_o         out 3          FSM state (ft_pkg encoding)
//   voted_addr_o    out 32         voted address of the last compare
//   voted_result_o  out DW         voted ALU result of the last compare
//   mismatch_mask_o out NCORES     sticky per-core mismatch mask
//   mismatch_cnt_o  out 8          saturating mismatch event count
//   cycle_cnt_o     out 32         RUN cycle count
//   result_o        out DW         latched program result
//   done_o / timeout_o / fault_o   state level flags
// ----------------------------------------------------------------------------
module ft_lockstep_monitor
    import ft_pkg::*;
#(
    parameter int NCORES       = 2,
    parameter int DW           = 32,
    parameter int TIMEOUT_CYC  = 1000,
    parameter int MAX_MISMATCH = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [NCORES-1:0]    core_valid_i,
    input  logic [NCORES*32-1:0] instr_addr_i,
    input  logic [NCORES*DW-1:0] alu_result_i,
    input  logic                 mem_flag_i,
    input  logic [DW-1:0]        mem_result_i,
    output logic [2:0]           state_o,
    output logic [31:0]          voted_addr_o,
    output logic [DW-1:0]        voted_result_o,
    output logic [NCORES-1:0]    mismatch_mask_o,
    output logic [7:0]           mismatch_cnt_o,
    output logic [31:0]          cycle_cnt_o,
    output logic [DW-1:0]        result_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic                 fault_o
);

    localparam int TW = 32 + DW;

    logic [NCORES*TW-1:0] tuples;
    logic [TW-1:0]        voted;
    logic [NCORES-1:0]    differ;

    state_t               state_q,     state_d;
    logic [31:0]          cycleCnt_q,  cycleCnt_d;
    logic [7:0]           misCnt_q,    misCnt_d;
    logic [NCORES-1:0]    mask_q,      mask_d;
    logic [31:0]          votedAddr_q, votedAddr_d;
    logic [DW-1:0]        votedRes_q,  votedRes_d;
    logic [DW-1:0]        result_q,    result_d;
    logic                 done_q,      done_d;
    logic                 timeout_q,   timeout_d;
    logic                 fault_q,     fault_d;

    logic                 compareEn;
    logic                 anyDiff;
    logic [7:0]           misCntNext;

    for (genvar k = 0; k < NCORES; k++) begin : g_tuple
        assign tuples[k*TW +: TW] = {instr_addr_i[k*32 +: 32], alu_result_i[k*DW +: DW]};
    end

    ft_majority_voter #(
        .NCORES (NCORES),
        .W      (TW)
    ) u_voter (
        .values_i (tuples),
        .voted_o  (voted),
        .differ_o (differ)
    );

    assign compareEn  = (state_q == ST_RUN) && (&core_valid_i);
    assign anyDiff    = |differ;
    assign misCntNext = anyDiff ? satInc(misCnt_q) : misCnt_q;

    // Next-state logic. The cycle counter only advances on RUN cycles that
    // stay in RUN, so a terminal state shows the count it was reached at.
    // A compare still lands in the cycle that leaves RUN.
    always_comb begin
        state_d     = state_q;
        cycleCnt_d  = cycleCnt_q;
        misCnt_d    = misCnt_q;
        mask_d      = mask_q;
        votedAddr_d = votedAddr_q;
        votedRes_d  = votedRes_q;
        result_d    = result_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT, ST_FAULT: begin
                if (start_i) begin
                    state_d    = ST_RUN;
                    cycleCnt_d = '0;
                    misCnt_d   = '0;
                    mask_d     = '0;
                    result_d   = '0;
                end
            end
            ST_RUN: begin
                if (compareEn) begin
                    votedAddr_d = voted[TW-1:DW];
                    votedRes_d  = voted[DW-1:0];
                    mask_d      = mask_q | differ;
                    misCnt_d    = misCntNext;
                end
                if (compareEn && anyDiff && (misCntNext >= 8'(MAX_MISMATCH))) begin
                    state_d = ST_FAULT;
                end else if (mem_flag_i) begin
                    state_d  = ST_DONE;
                    result_d = mem_result_i;
                end else if (cycleCnt_q == 32'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    cycleCnt_d = cycleCnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d    = (state_d == ST_DONE);
        timeout_d = (state_d == ST_TIMEOUT);
        fault_d   = (state_d == ST_FAULT);
    end

    // State and output registers; reset wins over any start or run activity
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cycleCnt_q  <= '0;
            misCnt_q    <= '0;
            mask_q      <= '0;
            votedAddr_q <= '0;
            votedRes_q  <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycleCnt_q  <= cycleCnt_d;
            misCnt_q    <= misCnt_d;
            mask_q      <= mask_d;
            votedAddr_q <= votedAddr_d;
            votedRes_q  <= votedRes_d;
            result_q    <= result_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            fault_q     <= fault_d;
        end
    end

    assign state_o         = state_q;
    assign voted_addr_o    = votedAddr_q;
    assign voted_result_o  = votedRes_q;
    assign mismatch_mask_o = mask_q;
    assign mismatch_cnt_o  = misCnt_q;
    assign cycle_cnt_o     = cycleCnt_q;
    assign result_o        = result_q;
    assign done_o          = done_q;
    assign timeout_o       = timeout_q;
    assign fault_o         = fault_q;

endmodule

// File: tb/tb_ft_lockstep_monitor.sv
// ----------------------------------------------------------------------------
// tb_ft_lockstep_monitor
// Two monitor instances share the clock and reset:
//   dutA : NCORES=2, TIMEOUT_CYC=1000, MAX_MISMATCH=3
//   dutB : NCORES=3, TIMEOUT_CYC=20,   MAX_MISMATCH=3
// Inputs change 1 time unit after the rising edge; outputs are read there too.
// ----------------------------------------------------------------------------
module tb_ft_lockstep_monitor;

    logic clk;
    logic rst;

    // dutA signals
    logic        startA, flagA;
    logic [1:0]  validA;
    logic [63:0] addrA, aluA;
    logic [31:0] memResA;
    logic [2:0]  stateA;
    logic [31:0] vAddrA, vResA, cycA, resA;
    logic [1:0]  maskA;
    logic [7:0]  cntA;
    logic        doneA, toA, faultA;

    // dutB signals
    logic        startB, flagB;
    logic [2:0]  validB;
    logic [95:0] addrB, aluB;
    logic [31:0] memResB;
    logic [2:0]  stateB;
    logic [31:0] vAddrB, vResB, cycB, resB;
    logic [2:0]  maskB;
    logic [7:0]  cntB;
    logic        doneB, toB, faultB;

    int errors = 0;
    int checks = 0;

    ft_lockstep_monitor #(.NCORES(2), .DW(32), .TIMEOUT_CYC(1000), .MAX_MISMATCH(3)) dutA (
        .clk_i(clk), .rst_i(rst), .start_i(startA), .core_valid_i(validA),
        .instr_addr_i(addrA), .alu_result_i(aluA), .mem_flag_i(flagA), .mem_result_i(memResA),
        .state_o(stateA), .voted_addr_o(vAddrA), .voted_result_o(vResA),
        .mismatch_mask_o(maskA), .mismatch_cnt_o(cntA), .cycle_cnt_o(cycA),
        .result_o(resA), .done_o(doneA), .timeout_o(toA), .fault_o(faultA)
    );

    ft_lockstep_monitor #(.NCORES(3), .DW(32), .TIMEOUT_CYC(20), .MAX_MISMATCH(3)) dutB (
        .clk_i(clk), .rst_i(rst), .start_i(startB), .core_valid_i(validB),
        .instr_addr_i(addrB), .alu_result_i(aluB), .mem_flag_i(flagB), .mem_result_i(memResB),
        .state_o(stateB), .voted_addr_o(vAddrB), .voted_result_o(vResB),
        .mismatch_mask_o(maskB), .mismatch_cnt_o(cntB), .cycle_cnt_o(cycB),
        .result_o(resB), .done_o(doneB), .timeout_o(toB), .fault_o(faultB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset state, then confirm nothing counts until start is seen
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (stateA !== 3'd0) begin $display("[TB] FAIL reset_stateA: got %0d expected 0", stateA); errors++; end
        checks++; if (cycA !== 32'd0) begin $display("[TB] FAIL reset_cycA: got %0d expected 0", cycA); errors++; end
        checks++; if ({doneA, toA, faultA} !== 3'b000) begin $display("[TB] FAIL reset_flagsA: got %b expected 000", {doneA, toA, faultA}); errors++; end
        checks++; if (vAddrA !== 32'd0) begin $display("[TB] FAIL reset_vaddrA: got %0h expected 0", vAddrA); errors++; end
        checks++; if ({stateB, maskB, cntB} !== 14'd0) begin $display("[TB] FAIL reset_B: got %0h expected 0", {stateB, maskB, cntB}); errors++; end
        rst    = 1'b0;
        validA = 2'b11;
        addrA  = {32'h0000_2000, 32'h0000_1000};
        aluA   = {32'd5, 32'd4};
        tick();
        tick();
        checks++; if (stateA !== 3'd0) begin $display("[TB] FAIL idle_no_start_state: got %0d expected 0", stateA); errors++; end
        checks++; if (cntA !== 8'd0) begin $display("[TB] FAIL idle_no_compare: got %0d expected 0", cntA); errors++; end
        checks++; if (cycA !== 32'd0) begin $display("[TB] FAIL idle_no_count: got %0d expected 0", cycA); errors++; end
    endtask

    // Identical streams on two cores, completion flag once the count hits 40
    task automatic test_done_identical();
        startA = 1'b1;
        tick();
        startA = 1'b0;
        checks++; if (stateA !== 3'd1) begin $display("[TB] FAIL start_stateA: got %0d expected 1", stateA); errors++; end
        checks++; if (cycA !== 32'd0) begin $display("[TB] FAIL start_cycA: got %0d expected 0", cycA); errors++; end
        for (int i = 0; i < 40; i++) begin
            validA = 2'b11;
            addrA  = {2{32'h0000_1000 + 32'(4 * i)}};
            aluA   = {2{32'(3 * i)}};
            startA = (i == 20);
            tick();
            if (i == 0) begin
                checks++; if (vAddrA !== 32'h0000_1000) begin $display("[TB] FAIL voted_latency: got %0h expected 1000", vAddrA); errors++; end
            end
        end
        startA = 1'b0;
        checks++; if (cycA !== 32'd40) begin $display("[TB] FAIL run_cyc40: got %0d expected 40", cycA); errors++; end
        checks++; if (vAddrA !== 32'h0000_109C) begin $display("[TB] FAIL run_vaddr: got %0h expected 109c", vAddrA); errors++; end
        checks++; if (vResA !== 32'd117) begin $display("[TB] FAIL run_vres: got %0d expected 117", vResA); errors++; end
        flagA   = 1'b1;
        memResA = 32'd55;
        tick();
        flagA = 1'b0;
        checks++; if (stateA !== 3'd2) begin $display("[TB] FAIL done_state: got %0d expected 2", stateA); errors++; end
        checks++; if (resA !== 32'd55) begin $display("[TB] FAIL done_result: got %0d expected 55", resA); errors++; end
        checks++; if (cntA !== 8'd0) begin $display("[TB] FAIL done_mismatch: got %0d expected 0", cntA); errors++; end
        checks++; if (cycA !== 32'd40) begin $display("[TB] FAIL done_cyc: got %0d expected 40", cycA); errors++; end
        checks++; if ({doneA, toA, faultA} !== 3'b100) begin $display("[TB] FAIL done_flags: got %b expected 100", {doneA, toA, faultA}); errors++; end
        tick();
        checks++; if (cycA !== 32'd40) begin $display("[TB] FAIL done_frozen: got %0d expected 40", cycA); errors++; end
    endtask

    // Partial valid is ignored; a full-valid 1:1 split blames core 1 only
    task automatic test_partial_valid();
        startA = 1'b1;
        tick();
        startA = 1'b0;
        checks++; if ({resA, cntA, cycA} !== 72'd0) begin $display("[TB] FAIL restart_clear: got %0h expected 0", {resA, cntA, cycA}); errors++; end
        validA = 2'b01;
        addrA  = {32'h0000_2000, 32'h0000_1000};
        aluA   = {32'd9, 32'd8};
        tick();
        checks++; if (cntA !== 8'd0) begin $display("[TB] FAIL partial_cnt: got %0d expected 0", cntA); errors++; end
        checks++; if (maskA !== 2'b00) begin $display("[TB] FAIL partial_mask: got %b expected 00", maskA); errors++; end
        checks++; if (vAddrA !== 32'h0000_109C) begin $display("[TB] FAIL partial_hold: got %0h expected 109c", vAddrA); errors++; end
        validA = 2'b11;
        tick();
        validA = 2'b00;
        checks++; if (cntA !== 8'd1) begin $display("[TB] FAIL split_cnt: got %0d expected 1", cntA); errors++; end
        checks++; if (maskA !== 2'b10) begin $display("[TB] FAIL split_mask: got %b expected 10", maskA); errors++; end
        checks++; if ({vAddrA, vResA} !== {32'h0000_1000, 32'd8}) begin $display("[TB] FAIL split_voted: got %0h expected 100000000008", {vAddrA, vResA}); errors++; end
        checks++; if (cycA !== 32'd2) begin $display("[TB] FAIL split_cyc: got %0d expected 2", cycA); errors++; end
        flagA   = 1'b1;
        memResA = 32'h77;
        tick();
        flagA = 1'b0;
        checks++; if ({stateA, resA} !== {3'd2, 32'h77}) begin $display("[TB] FAIL split_done: got %0h expected 200000077", {stateA, resA}); errors++; end
    endtask

    // Three cores, core 2 off by one on three compares
    task automatic test_fault_mismatch();
        startB = 1'b1;
        tick();
        startB = 1'b0;
        for (int i = 0; i < 3; i++) begin
            validB = 3'b111;
            addrB  = {3{32'h0000_0400 + 32'(4 * i)}};
            aluB   = {32'(101 + i), 32'(100 + i), 32'(100 + i)};
            tick();
            if (i == 0) begin
                checks++; if ({stateB, cntB, maskB} !== {3'd1, 8'd1, 3'b100}) begin $display("[TB] FAIL fault_first: got %0h expected %0h", {stateB, cntB, maskB}, {3'd1, 8'd1, 3'b100}); errors++; end
                checks++; if (vResB !== 32'd100) begin $display("[TB] FAIL fault_vres1: got %0d expected 100", vResB); errors++; end
                validB = 3'b011;
                tick();
                checks++; if (cntB !== 8'd1) begin $display("[TB] FAIL fault_partial: got %0d expected 1", cntB); errors++; end
            end
            if (i == 1) begin
                checks++; if ({stateB, cntB} !== {3'd1, 8'd2}) begin $display("[TB] FAIL fault_second: got %0h expected 102", {stateB, cntB}); errors++; end
            end
        end
        checks++; if (stateB !== 3'd4) begin $display("[TB] FAIL fault_state: got %0d expected 4", stateB); errors++; end
        checks++; if ({doneB, toB, faultB} !== 3'b001) begin $display("[TB] FAIL fault_flags: got %b expected 001", {doneB, toB, faultB}); errors++; end
        checks++; if (maskB !== 3'b100) begin $display("[TB] FAIL fault_mask: got %b expected 100", maskB); errors++; end
        checks++; if (vResB !== 32'd102) begin $display("[TB] FAIL fault_vres: got %0d expected 102", vResB); errors++; end
        checks++; if (cycB !== 32'd3) begin $display("[TB] FAIL fault_cyc: got %0d expected 3", cycB); errors++; end
        tick();
        checks++; if (cntB !== 8'd3) begin $display("[TB] FAIL fault_frozen: got %0d expected 3", cntB); errors++; end
    endtask

    // No completion flag: TIMEOUT_CYC=20 stops the run at count 19
    task automatic test_timeout();
        validB = 3'b000;
        startB = 1'b1;
        tick();
        startB = 1'b0;
        checks++; if ({stateB, cntB, maskB, cycB} !== {3'd1, 8'd0, 3'd0, 32'd0}) begin $display("[TB] FAIL to_restart: got %0h expected %0h", {stateB, cntB, maskB, cycB}, {3'd1, 8'd0, 3'd0, 32'd0}); errors++; end
        repeat (19) tick();
        checks++; if ({stateB, cycB} !== {3'd1, 32'd19}) begin $display("[TB] FAIL to_before: got %0h expected 100000013", {stateB, cycB}); errors++; end
        tick();
        checks++; if (stateB !== 3'd3) begin $display("[TB] FAIL to_state: got %0d expected 3", stateB); errors++; end
        checks++; if (cycB !== 32'd19) begin $display("[TB] FAIL to_cyc: got %0d expected 19", cycB); errors++; end
        checks++; if ({doneB, toB, faultB} !== 3'b010) begin $display("[TB] FAIL to_flags: got %b expected 010", {doneB, toB, faultB}); errors++; end
    endtask

    // Third mismatch and completion flag together: FAULT wins, no result
    task automatic test_fault_beats_done();
        startB = 1'b1;
        tick();
        startB = 1'b0;
        validB = 3'b111;
        addrB  = {3{32'h0000_0500}};
        aluB   = {32'd8, 32'd8, 32'd7};
        tick();
        checks++; if ({maskB, vResB} !== {3'b001, 32'd8}) begin $display("[TB] FAIL fbd_core0_minority: got %0h expected 100000008", {maskB, vResB}); errors++; end
        aluB = {32'd9, 32'd10, 32'd9};
        tick();
        checks++; if ({maskB, vResB, cntB} !== {3'b011, 32'd9, 8'd2}) begin $display("[TB] FAIL fbd_core1_minority: got %0h expected %0h", {maskB, vResB, cntB}, {3'b011, 32'd9, 8'd2}); errors++; end
        aluB    = {32'd13, 32'd12, 32'd11};
        flagB   = 1'b1;
        memResB = 32'd99;
        tick();
        flagB  = 1'b0;
        validB = 3'b000;
        checks++; if (stateB !== 3'd4) begin $display("[TB] FAIL fbd_state: got %0d expected 4", stateB); errors++; end
        checks++; if (resB !== 32'd0) begin $display("[TB] FAIL fbd_result: got %0d expected 0", resB); errors++; end
        checks++; if (doneB !== 1'b0) begin $display("[TB] FAIL fbd_done: got %0d expected 0", doneB); errors++; end
        checks++; if ({maskB, vResB, cntB} !== {3'b111, 32'd11, 8'd3}) begin $display("[TB] FAIL fbd_tie: got %0h expected %0h", {maskB, vResB, cntB}, {3'b111, 32'd11, 8'd3}); errors++; end
    endtask

    // Reset pulsed at cycle 10 of a run, with start held high alongside it
    task automatic test_reset_mid_run();
        startA = 1'b1;
        tick();
        startA = 1'b0;
        validA = 2'b11;
        addrA  = {2{32'h0000_3000}};
        aluA   = {2{32'd42}};
        repeat (10) tick();
        checks++; if ({cycA, vResA} !== {32'd10, 32'd42}) begin $display("[TB] FAIL mid_before: got %0h expected a0000002a", {cycA, vResA}); errors++; end
        rst    = 1'b1;
        startA = 1'b1;
        tick();
        checks++; if (stateA !== 3'd0) begin $display("[TB] FAIL mid_state: got %0d expected 0", stateA); errors++; end
        checks++; if ({vAddrA, vResA, maskA, cntA, cycA, resA, doneA, toA, faultA} !== 141'd0) begin $display("[TB] FAIL mid_outputs: got %0h expected 0", {vAddrA, vResA, maskA, cntA, cycA, resA, doneA, toA, faultA}); errors++; end
        checks++; if (faultB !== 1'b0) begin $display("[TB] FAIL mid_B_fault: got %0d expected 0", faultB); errors++; end
        rst    = 1'b0;
        startA = 1'b0;
        tick();
        checks++; if ({stateA, cycA} !== 35'd0) begin $display("[TB] FAIL mid_idle: got %0h expected 0", {stateA, cycA}); errors++; end
        startA = 1'b1;
        tick();
        startA = 1'b0;
        repeat (3) tick();
        checks++; if ({stateA, cycA} !== {3'd1, 32'd3}) begin $display("[TB] FAIL mid_restart: got %0h expected 100000003", {stateA, cycA}); errors++; end
    endtask

    initial begin
        rst = 1'b1;
        startA = 1'b0; flagA = 1'b0; validA = '0; addrA = '0; aluA = '0; memResA = '0;
        startB = 1'b0; flagB = 1'b0; validB = '0; addrB = '0; aluB = '0; memResB = '0;
        test_reset();
        test_done_identical();
        test_partial_valid();
        test_fault_mismatch();
        test_timeout();
        test_fault_beats_done();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
